// File: rtl/game_state_ctrl_pkg.sv
// Shared encodings for the rhythm-game flow controller: FSM states and the
// fixed roles of the first three buttons.
package game_pkg;

   typedef enum logic [2:0] {
      ST_START  = 3'd0,
      ST_MENU   = 3'd1,
      ST_PLAY   = 3'd2,
      ST_FINISH = 3'd3,
      ST_PAUSE  = 3'd4
   } state_t;

   localparam int BTN_PREV = 0;
   localparam int BTN_NEXT = 1;
   localparam int BTN_CONF = 2;

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// One button: 2-FF synchroniser, stability counter, arm flag and a registered
// one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);

   logic          sync1;
   logic          sync2;
   logic          level_d;
   logic          arm;
   logic [CW-1:0] cnt;

   // The synchroniser keeps tracking the pin through reset so a held button
   // is still seen as held once reset drops.
   always_ff @(posedge clk) begin
      sync1 <= raw;
      sync2 <= sync1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         arm     <= 1'b0;
         cnt     <= '0;
      end else begin
         level_d <= level;
         press   <= level & ~level_d & arm;
         // Reset forces level low, so arming also waits for the pin itself to be low.
         if (!level && !sync2)
            arm <= 1'b1;
         if (DEBOUNCE_CYC == 0) begin
            level <= sync2;
         end else if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: debounced buttons, START/MENU/PLAY/PAUSE/FINISH FSM,
// wrap-around song selection and an idle return-to-START timeout.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int NUM_BTN      = 3,
   parameter int NUM_SONGS    = 3,
   parameter int DEBOUNCE_CYC = 16,
   parameter int IDLE_TIMEOUT = 1000000,
   parameter int PAUSE_EN     = 1,
   localparam int SW          = $clog2(NUM_SONGS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               finish,
   output logic [2:0]         state,
   output logic [SW-1:0]      song_select,
   output logic [SW-1:0]      song_confirm,
   output logic               confirm_pulse,
   output logic               abort_pulse,
   output logic               paused,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press
);

   localparam int IW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
   localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

   state_t        st;
   logic [IW-1:0] idle;
   logic          both_d;
   logic          chord;
   logic          any_press;
   logic          nav_prev;
   logic          nav_next;
   logic          idle_hit;
   logic [SW-1:0] sel_dec;
   logic [SW-1:0] sel_inc;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (btn_raw[i]),
         .level (btn_level[i]),
         .press (btn_press[i])
      );
   end

   // Chord is registered so it lines up with the press pulses of the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         both_d <= 1'b0;
         chord  <= 1'b0;
      end else begin
         both_d <= btn_level[BTN_PREV] & btn_level[BTN_NEXT];
         chord  <= btn_level[BTN_PREV] & btn_level[BTN_NEXT] & ~both_d;
      end
   end

   assign any_press = |btn_press;
   assign nav_prev  = btn_press[BTN_PREV] & ~btn_press[BTN_NEXT] & ~chord;
   assign nav_next  = btn_press[BTN_NEXT] & ~btn_press[BTN_PREV] & ~chord;
   assign idle_hit  = (IDLE_TIMEOUT != 0) && !any_press && (idle == IDLE_LAST);
   assign sel_dec   = (song_select == SW'(1)) ? SW'(NUM_SONGS) : song_select - SW'(1);
   assign sel_inc   = (song_select == SW'(NUM_SONGS)) ? SW'(1) : song_select + SW'(1);
   assign state     = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st            <= ST_START;
         song_select   <= SW'(1);
         song_confirm  <= '0;
         confirm_pulse <= 1'b0;
         abort_pulse   <= 1'b0;
         paused        <= 1'b0;
         idle          <= '0;
      end else begin
         confirm_pulse <= 1'b0;
         abort_pulse   <= 1'b0;
         // Transitions that leave MENU/FINISH without a press clear idle explicitly below.
         if ((st == ST_MENU || st == ST_FINISH) && !any_press)
            idle <= idle + 1'b1;
         else
            idle <= '0;

         case (st)
            ST_START: begin
               if (any_press)
                  st <= ST_MENU;
            end
            ST_MENU: begin
               if (btn_press[BTN_CONF] && song_select != '0) begin
                  st            <= ST_PLAY;
                  song_confirm  <= song_select;
                  confirm_pulse <= 1'b1;
               end else if (idle_hit) begin
                  st   <= ST_START;
                  idle <= '0;
               end else if (nav_prev) begin
                  song_select <= sel_dec;
               end else if (nav_next) begin
                  song_select <= sel_inc;
               end
            end
            ST_PLAY: begin
               if (finish) begin
                  st <= ST_FINISH;
               end else if (chord && PAUSE_EN != 0) begin
                  st     <= ST_PAUSE;
                  paused <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (chord) begin
                  st     <= ST_PLAY;
                  paused <= 1'b0;
               end else if (btn_press[BTN_CONF]) begin
                  st           <= ST_MENU;
                  paused       <= 1'b0;
                  abort_pulse  <= 1'b1;
                  song_confirm <= '0;
               end
            end
            ST_FINISH: begin
               if (btn_press[BTN_CONF]) begin
                  st           <= ST_MENU;
                  song_confirm <= '0;
               end else if (idle_hit) begin
                  st           <= ST_START;
                  song_confirm <= '0;
                  idle         <= '0;
               end
            end
            default: begin
               st           <= ST_START;
               paused       <= 1'b0;
               song_confirm <= '0;
               idle         <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus randomized button traffic
// compared cycle by cycle against a behavioural model of the game flow.
module tb_game_state_ctrl;

   localparam int NB = 3;
   localparam int NS = 3;
   localparam int DC = 4;
   localparam int IT = 20;
   localparam int SW = 2;
   localparam int VW = 3 + 2*SW + 3 + 2*NB;

   localparam int S_START  = 0;
   localparam int S_MENU   = 1;
   localparam int S_PLAY   = 2;
   localparam int S_FINISH = 3;
   localparam int S_PAUSE  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn_raw;
   logic          finish;
   logic [2:0]    state;
   logic [SW-1:0] song_select;
   logic [SW-1:0] song_confirm;
   logic          confirm_pulse;
   logic          abort_pulse;
   logic          paused;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   bit [NB-1:0] m_d1, m_d2, m_lvl, m_lvl_q, m_arm, m_prs;
   int          m_run[NB];
   bit          m_both_q, m_chord, m_cp, m_ap;
   int          m_state, m_sel, m_conf, m_quiet;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .NUM_BTN(NB), .NUM_SONGS(NS), .DEBOUNCE_CYC(DC), .IDLE_TIMEOUT(IT), .PAUSE_EN(1)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .finish(finish), .state(state),
      .song_select(song_select), .song_confirm(song_confirm),
      .confirm_pulse(confirm_pulse), .abort_pulse(abort_pulse), .paused(paused),
      .btn_level(btn_level), .btn_press(btn_press)
   );

   // Advance the model by one clock edge using the inputs sampled at that edge.
   task automatic model_step();
      bit [NB-1:0] lvl_n, prs_n, arm_n;
      int st_n;
      if (rst) begin
         m_state = S_START; m_sel = 1; m_conf = 0; m_cp = 0; m_ap = 0; m_quiet = 0;
         m_chord = 0; m_both_q = 0; m_lvl = '0; m_lvl_q = '0; m_prs = '0; m_arm = '0;
         for (int i = 0; i < NB; i++) m_run[i] = 0;
      end else begin
         st_n = m_state; m_cp = 0; m_ap = 0;
         case (m_state)
            S_START:  if (m_prs != 0) st_n = S_MENU;
            S_MENU: begin
               if (m_prs[2]) begin st_n = S_PLAY; m_conf = m_sel; m_cp = 1; end
               else if (m_prs == 0 && m_quiet + 1 == IT) st_n = S_START;
               else if (!m_chord && m_prs[0] && !m_prs[1]) m_sel = (m_sel == 1) ? NS : m_sel - 1;
               else if (!m_chord && m_prs[1] && !m_prs[0]) m_sel = (m_sel == NS) ? 1 : m_sel + 1;
            end
            S_PLAY: begin
               if (finish) st_n = S_FINISH;
               else if (m_chord) st_n = S_PAUSE;
            end
            S_PAUSE: begin
               if (m_chord) st_n = S_PLAY;
               else if (m_prs[2]) begin st_n = S_MENU; m_ap = 1; m_conf = 0; end
            end
            S_FINISH: begin
               if (m_prs[2]) begin st_n = S_MENU; m_conf = 0; end
               else if (m_prs == 0 && m_quiet + 1 == IT) begin st_n = S_START; m_conf = 0; end
            end
            default: st_n = S_START;
         endcase
         if (st_n != m_state || !(m_state == S_MENU || m_state == S_FINISH) || m_prs != 0) m_quiet = 0;
         else m_quiet++;
         m_state = st_n;
         for (int i = 0; i < NB; i++) begin
            prs_n[i] = m_lvl[i] & ~m_lvl_q[i] & m_arm[i];
            arm_n[i] = m_arm[i] | (~m_lvl[i] & ~m_d2[i]);
            lvl_n[i] = m_lvl[i];
            if (m_d2[i] == m_lvl[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] == DC) begin lvl_n[i] = ~m_lvl[i]; m_run[i] = 0; end
            end
         end
         m_chord  = m_lvl[0] & m_lvl[1] & ~m_both_q;
         m_both_q = m_lvl[0] & m_lvl[1];
         m_lvl_q = m_lvl; m_lvl = lvl_n; m_prs = prs_n; m_arm = arm_n;
      end
      m_d2 = m_d1;
      m_d1 = btn_raw;
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic tap(input logic [NB-1:0] m);
      btn_raw = m;
      repeat (DC + 4) step();
      btn_raw = '0;
      repeat (DC + 4) step();
   endtask

   task automatic test_reset();
      rst = 1'b1; btn_raw = '0; finish = 1'b0;
      repeat (4) step();
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
      n_checks++; if (song_select !== 2'd1) begin n_fail++; $display("FAIL reset_select: got %0d want 1", song_select); end
      n_checks++; if (song_confirm !== 2'd0) begin n_fail++; $display("FAIL reset_confirm: got %0d want 0", song_confirm); end
      n_checks++; if ({confirm_pulse, abort_pulse, paused} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 000", {confirm_pulse, abort_pulse, paused}); end
      n_checks++; if ({btn_level, btn_press} !== '0) begin
         n_fail++; $display("FAIL reset_buttons: got %b want 0", {btn_level, btn_press}); end
      rst = 1'b0;
      repeat (3) step();
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_idle_state: got %0d want 0", state); end
   endtask

   task automatic test_bounce();
      int np = 0, nl = 0;
      for (int c = 0; c < 16; c++) begin
         btn_raw[2] = (((c >> 1) & 1) == 0);
         step();
         if (btn_press[2]) np++;
         if (btn_level[2]) nl++;
      end
      btn_raw = '0;
      repeat (4) begin step(); if (btn_press[2]) np++; if (btn_level[2]) nl++; end
      n_checks++; if (np != 0) begin n_fail++; $display("FAIL bounce_press: got %0d pulses want 0", np); end
      n_checks++; if (nl != 0) begin n_fail++; $display("FAIL bounce_level: got %0d high cycles want 0", nl); end
      n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL bounce_state: got %0d want 0", state); end
   endtask

   task automatic test_first_press();
      int press_at = -1, menu_at = -1, np = 0;
      btn_raw = 3'b010;
      for (int e = 1; e <= 12; e++) begin
         step();
         if (btn_press[1]) begin np++; if (press_at < 0) press_at = e; end
         if (state == 3'd1 && menu_at < 0) menu_at = e;
      end
      btn_raw = '0;
      repeat (6) step();
      n_checks++; if (press_at != DC + 3) begin n_fail++; $display("FAIL first_press_latency: got %0d want %0d", press_at, DC + 3); end
      n_checks++; if (np != 1) begin n_fail++; $display("FAIL first_press_width: got %0d want 1", np); end
      n_checks++; if (menu_at != DC + 4) begin n_fail++; $display("FAIL first_menu_edge: got %0d want %0d", menu_at, DC + 4); end
      n_checks++; if (song_select !== 2'd1) begin n_fail++; $display("FAIL first_select: got %0d want 1", song_select); end
   endtask

   task automatic test_select();
      tap(3'b001);
      n_checks++; if (song_select !== 2'd3) begin n_fail++; $display("FAIL sel_prev_wrap: got %0d want 3", song_select); end
      tap(3'b010);
      n_checks++; if (song_select !== 2'd1) begin n_fail++; $display("FAIL sel_next_wrap: got %0d want 1", song_select); end
      tap(3'b011);
      n_checks++; if (song_select !== 2'd1) begin n_fail++; $display("FAIL sel_both: got %0d want 1", song_select); end
      tap(3'b010);
      n_checks++; if (song_select !== 2'd2) begin n_fail++; $display("FAIL sel_next: got %0d want 2", song_select); end
      tap(3'b110);
      n_checks++; if (song_confirm !== 2'd2 || song_select !== 2'd2 || state !== 3'd2) begin
         n_fail++; $display("FAIL sel_conf_nav: got conf=%0d sel=%0d st=%0d want 2 2 2", song_confirm, song_select, state); end
      finish = 1'b1; repeat (2) step(); finish = 1'b0;
      tap(3'b100);
      n_checks++; if (state !== 3'(m_state) || state !== 3'd1) begin
         n_fail++; $display("FAIL sel_back_menu: got %0d want 1 (model %0d)", state, m_state); end
   endtask

   task automatic test_play_finish();
      int ncp = 0;
      btn_raw = 3'b100;
      repeat (DC + 4) begin step(); if (confirm_pulse) ncp++; end
      btn_raw = '0;
      repeat (DC + 4) begin step(); if (confirm_pulse) ncp++; end
      n_checks++; if (ncp != 1) begin n_fail++; $display("FAIL play_confirm_pulse: got %0d cycles want 1", ncp); end
      n_checks++; if (song_confirm !== 2'd2) begin n_fail++; $display("FAIL play_confirm_song: got %0d want 2", song_confirm); end
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL play_state: got %0d want 2", state); end
      finish = 1'b1; repeat (2) step(); finish = 1'b0;
      n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL finish_state: got %0d want 3", state); end
      tap(3'b100);
      n_checks++; if (state !== 3'd1 || song_confirm !== 2'd0) begin
         n_fail++; $display("FAIL finish_to_menu: got st=%0d conf=%0d want 1 0", state, song_confirm); end
   endtask

   task automatic test_pause();
      int nab = 0;
      tap(3'b100);
      n_checks++; if (state !== 3'd2) begin n_fail++; $display("FAIL pause_enter_play: got %0d want 2", state); end
      btn_raw = 3'b011;
      repeat (DC + 4) step();
      n_checks++; if (state !== 3'd4 || paused !== 1'b1) begin
         n_fail++; $display("FAIL pause_chord: got st=%0d paused=%b want 4 1", state, paused); end
      btn_raw = '0;
      repeat (DC + 4) step();
      finish = 1'b1; repeat (5) step(); finish = 1'b0;
      n_checks++; if (state !== 3'd4) begin n_fail++; $display("FAIL pause_ignores_finish: got %0d want 4", state); end
      btn_raw = 3'b100;
      repeat (DC + 4) begin step(); if (abort_pulse) nab++; end
      btn_raw = '0;
      repeat (DC + 4) begin step(); if (abort_pulse) nab++; end
      n_checks++; if (nab != 1) begin n_fail++; $display("FAIL pause_abort_pulse: got %0d cycles want 1", nab); end
      n_checks++; if (state !== 3'd1 || song_confirm !== 2'd0 || paused !== 1'b0) begin
         n_fail++; $display("FAIL pause_abort: got st=%0d conf=%0d paused=%b want 1 0 0", state, song_confirm, paused); end
   endtask

   task automatic test_idle();
      int s = 0;
      bit mid_ok;
      btn_raw = 3'b010;
      while (!btn_press[1] && s < 20) begin step(); s++; end
      btn_raw = '0;
      n_checks++; if (!btn_press[1]) begin n_fail++; $display("FAIL idle_nav_press: no press within %0d cycles", s); end
      s = 0;
      while (state !== 3'd0 && s < 60) begin step(); s++; end
      n_checks++; if (s != IT + 1) begin n_fail++; $display("FAIL idle_timeout: got %0d cycles want %0d", s, IT + 1); end
      // from START, leave via prev, then a next press 19 cycles into MENU
      btn_raw = 3'b001; s = 0;
      while (!btn_press[0] && s < 20) begin step(); s++; end
      btn_raw = '0;
      s = 0; mid_ok = 1'b0;
      while (s < 90) begin
         step(); s++;
         if (s == 13) btn_raw = 3'b010;
         if (s == 21) begin btn_raw = '0; mid_ok = (state === 3'd1); end
         if (s > 21 && state === 3'd0) break;
      end
      n_checks++; if (!mid_ok) begin n_fail++; $display("FAIL idle_restart_hold: state left MENU before cycle 21 (now %0d)", state); end
      n_checks++; if (s != 41) begin n_fail++; $display("FAIL idle_restart: got %0d cycles want 41", s); end
      n_checks++; if (song_select !== 2'(m_sel)) begin n_fail++; $display("FAIL idle_select: got %0d want %0d", song_select, m_sel); end
   endtask

   task automatic test_held_reset();
      int np = 0;
      btn_raw = 3'b001;
      repeat (10) step();
      rst = 1'b1; repeat (2) step(); rst = 1'b0;
      repeat (12) begin step(); if (btn_press[0]) np++; end
      n_checks++; if (np != 0 || state !== 3'd0) begin
         n_fail++; $display("FAIL held_reset_press: got %0d pulses st=%0d want 0 0", np, state); end
      n_checks++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL held_reset_level: got %b want 1", btn_level[0]); end
      btn_raw = '0;
      repeat (10) begin step(); if (btn_press[0]) np++; end
      btn_raw = 3'b001;
      repeat (10) begin step(); if (btn_press[0]) np++; end
      btn_raw = '0;
      repeat (8) step();
      n_checks++; if (np != 1 || state !== 3'd1) begin
         n_fail++; $display("FAIL held_reset_repress: got %0d pulses st=%0d want 1 1", np, state); end
   endtask

   task automatic test_random();
      int left = 0;
      logic [VW-1:0] got, exp;
      for (int c = 0; c < 800; c++) begin
         if (left == 0) begin
            btn_raw = NB'($urandom_range(0, 7));
            left    = $urandom_range(1, 14);
            finish  = ($urandom_range(0, 5) == 0);
         end
         left--;
         rst = ($urandom_range(0, 299) == 0);
         step();
         exp = {3'(m_state), SW'(m_sel), SW'(m_conf), m_cp, m_ap, (m_state == S_PAUSE), m_lvl, m_prs};
         got = {state, song_select, song_confirm, confirm_pulse, abort_pulse, paused, btn_level, btn_press};
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL random_cycle_%0d: got %h want %h (st/sel/conf/cp/ap/pz/lvl/prs)", c, got, exp);
         end
      end
      rst = 1'b0; btn_raw = '0; finish = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_bounce();
      test_first_press();
      test_select();
      test_play_finish();
      test_pause();
      test_idle();
      test_held_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
